// File: rtl/stopwatch_cmd_gen_pkg.sv
// ============================================================================
// stopwatch_cmd_gen_pkg : shared stopwatch constants, command encoding, arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package stopwatch_cmd_gen_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int CNT_W_DEF           = 20;

  // Bit positions inside btn_level
  localparam int BTN_START = 0;
  localparam int BTN_STOP  = 1;
  localparam int BTN_RESET = 2;
  localparam int NUM_BTN   = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10
  } sw_status_e;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_START = 2'b01,
    CMD_STOP  = 2'b10,
    CMD_RESET = 2'b11
  } cmd_e;

  // Only one command may leave per cycle; stop beats start beats reset.
  function automatic cmd_e arbitrate(input logic [NUM_BTN-1:0] rise);
    cmd_e cmd;
    cmd = CMD_NONE;
    if (rise[BTN_STOP])       cmd = CMD_STOP;
    else if (rise[BTN_START]) cmd = CMD_START;
    else if (rise[BTN_RESET]) cmd = CMD_RESET;
    return cmd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stopwatch_cmd_gen_if.sv
// ============================================================================
// stopwatch_cmd_gen_if : raw button levels in, command strobes and levels out
// Rev 1.0
// ============================================================================
`default_nettype none

interface stopwatch_cmd_gen_if;

  logic       btn_start_raw;
  logic       btn_stop_raw;
  logic       btn_reset_raw;
  logic       start;
  logic       stop;
  logic       reset;
  logic [2:0] btn_level;

  // slave: the command generator itself
  modport slave (
    input  btn_start_raw,
    input  btn_stop_raw,
    input  btn_reset_raw,
    output start,
    output stop,
    output reset,
    output btn_level
  );

  // master: whatever drives the buttons and consumes the commands
  modport master (
    output btn_start_raw,
    output btn_stop_raw,
    output btn_reset_raw,
    input  start,
    input  stop,
    input  reset,
    input  btn_level
  );

endinterface

`default_nettype wire

// File: rtl/stopwatch_cmd_gen_btn_debounce.sv
// ============================================================================
// stopwatch_cmd_gen_btn_debounce : 2-flop synchroniser plus counter debouncer
// Rev 1.0
// ============================================================================
`default_nettype none

module stopwatch_cmd_gen_btn_debounce
  import stopwatch_cmd_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any return to the stable level wipes the count: no partial credit.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_o   = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      rise_o   = sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = stable_q;

endmodule

`default_nettype wire

// File: rtl/stopwatch_cmd_gen.sv
// ============================================================================
// stopwatch_cmd_gen : debounced start/stop/reset buttons to one-hot command pulses
// Rev 1.0
// ============================================================================
`default_nettype none

module stopwatch_cmd_gen
  import stopwatch_cmd_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  wire                 clk,
  input  wire                 rst_n,
  stopwatch_cmd_gen_if.slave  bus
);

  generate
    if (DEBOUNCE_CYCLES < 2 || (64'(1) << CNT_W) <= 64'(DEBOUNCE_CYCLES - 1)) begin : g_param_check
      $error("stopwatch_cmd_gen: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
    end
  endgenerate

  logic [NUM_BTN-1:0] raw_vec;
  logic [NUM_BTN-1:0] level_vec;
  logic [NUM_BTN-1:0] rise_vec;
  cmd_e               cmd_d;
  logic               start_q;
  logic               stop_q;
  logic               reset_q;

  always_comb begin
    raw_vec            = '0;
    raw_vec[BTN_START] = bus.btn_start_raw;
    raw_vec[BTN_STOP]  = bus.btn_stop_raw;
    raw_vec[BTN_RESET] = bus.btn_reset_raw;
  end

  generate
    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
      stopwatch_cmd_gen_btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_i   (raw_vec[b]),
        .level_o (level_vec[b]),
        .rise_o  (rise_vec[b])
      );
    end
  endgenerate

  // Losing rises in the same cycle are dropped; their levels still update.
  always_comb begin
    cmd_d = arbitrate(rise_vec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      reset_q <= 1'b0;
    end else begin
      start_q <= (cmd_d == CMD_START);
      stop_q  <= (cmd_d == CMD_STOP);
      reset_q <= (cmd_d == CMD_RESET);
    end
  end

  assign bus.start     = start_q;
  assign bus.stop      = stop_q;
  assign bus.reset     = reset_q;
  assign bus.btn_level = level_vec;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_cmd_gen.sv
// ============================================================================
// tb_stopwatch_cmd_gen : directed and random button stimulus against a sample-window model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_stopwatch_cmd_gen;

  localparam int D = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   n_start_pulses;
  int   n_stop_pulses;
  int   n_reset_pulses;

  stopwatch_cmd_gen_if bus ();

  stopwatch_cmd_gen #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a level flips once the raw samples taken at edges n-D-1..n-2 all
  // disagree with it (two edges of synchroniser delay, then D in a row).
  logic [2:0] hist[$];
  logic [2:0] m_level;
  logic [2:0] m_cmd;

  always @(posedge clk or negedge rst_n) begin
    logic [2:0] rise;
    logic       all_diff;
    if (!rst_n) begin
      hist = {};
      for (int i = 0; i < D + 1; i++) hist.push_back(3'b000);
      m_level = 3'b000;
      m_cmd   = 3'b000;
    end else begin
      rise = 3'b000;
      hist.push_back({bus.btn_reset_raw, bus.btn_stop_raw, bus.btn_start_raw});
      for (int b = 0; b < 3; b++) begin
        all_diff = 1'b1;
        for (int k = 0; k < D; k++)
          if (hist[k][b] == m_level[b]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[b] = ~m_level[b];
          rise[b]    = m_level[b];
        end
      end
      void'(hist.pop_front());
      if (rise[1])      m_cmd = 3'b010;
      else if (rise[0]) m_cmd = 3'b001;
      else if (rise[2]) m_cmd = 3'b100;
      else              m_cmd = 3'b000;
    end
  end

  always @(negedge clk) begin
    check("start_vs_model", 32'(bus.start), 32'(m_cmd[0]));
    check("stop_vs_model", 32'(bus.stop), 32'(m_cmd[1]));
    check("reset_vs_model", 32'(bus.reset), 32'(m_cmd[2]));
    check("level_vs_model", 32'(bus.btn_level), 32'(m_level));
    check("onehot", 32'($countones({bus.start, bus.stop, bus.reset}) <= 1), 32'd1);
    n_start_pulses += int'(bus.start);
    n_stop_pulses  += int'(bus.stop);
    n_reset_pulses += int'(bus.reset);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int snap;
    n_checks = 0; n_fail = 0;
    n_start_pulses = 0; n_stop_pulses = 0; n_reset_pulses = 0;
    bus.btn_start_raw = 1'b0;
    bus.btn_stop_raw  = 1'b0;
    bus.btn_reset_raw = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    idle(3);
    check("rst_level", 32'(bus.btn_level), 32'd0);
    check("rst_cmds", 32'({bus.start, bus.stop, bus.reset}), 32'd0);
    rst_n = 1'b1;
    idle(5);

    // Clean press, held 50 cycles, release, press again
    snap = n_start_pulses;
    bus.btn_start_raw = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      check("press_start", 32'(bus.start), 32'(k == 5));
      check("press_level", 32'(bus.btn_level[0]), 32'(k == 5));
    end
    idle(44);
    bus.btn_start_raw = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      check("release_level", 32'(bus.btn_level[0]), 32'(k < 5));
    end
    idle(5);
    bus.btn_start_raw = 1'b1;
    idle(12);
    bus.btn_start_raw = 1'b0;
    idle(10);
    check("two_start_pulses", 32'(n_start_pulses - snap), 32'd2);

    // Simultaneous start and stop: stop wins, both levels rise
    snap = n_start_pulses;
    bus.btn_start_raw = 1'b1;
    bus.btn_stop_raw  = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      check("simul_stop", 32'(bus.stop), 32'(k == 5));
    end
    check("simul_level", 32'(bus.btn_level), 32'b011);
    idle(5);
    check("simul_no_start", 32'(n_start_pulses - snap), 32'd0);
    bus.btn_start_raw = 1'b0;
    bus.btn_stop_raw  = 1'b0;
    idle(10);

    // Bouncy stop press
    snap = n_stop_pulses;
    bus.btn_stop_raw = 1'b1; idle(2);
    bus.btn_stop_raw = 1'b0; idle(1);
    bus.btn_stop_raw = 1'b1; idle(15);
    check("bounce_one_stop", 32'(n_stop_pulses - snap), 32'd1);
    bus.btn_stop_raw = 1'b0;
    idle(10);

    // 3-cycle glitch on reset is rejected
    snap = n_reset_pulses;
    bus.btn_reset_raw = 1'b1; idle(3);
    bus.btn_reset_raw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("glitch_level", 32'(bus.btn_level), 32'd0);
    end
    check("glitch_no_reset", 32'(n_reset_pulses - snap), 32'd0);

    // Reset mid-debounce with stop already debounced high
    bus.btn_stop_raw = 1'b1;
    idle(8);
    bus.btn_start_raw = 1'b1;
    idle(4);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_level", 32'(bus.btn_level), 32'd0);
    check("async_rst_cmds", 32'({bus.start, bus.stop, bus.reset}), 32'd0);
    bus.btn_stop_raw = 1'b0;
    idle(2);
    rst_n = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      check("post_rst_start", 32'(bus.start), 32'(k == 5));
    end
    bus.btn_start_raw = 1'b0;
    idle(10);

    // Random bouncy activity on all three buttons
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) bus.btn_start_raw = ~bus.btn_start_raw;
      if ($urandom_range(0, 7) == 0) bus.btn_stop_raw  = ~bus.btn_stop_raw;
      if ($urandom_range(0, 7) == 0) bus.btn_reset_raw = ~bus.btn_reset_raw;
    end
    bus.btn_start_raw = 1'b0;
    bus.btn_stop_raw  = 1'b0;
    bus.btn_reset_raw = 1'b0;
    idle(20);
    check("final_level", 32'(bus.btn_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stopwatch_cmd_gen.md
Name: stopwatch_cmd_gen

Overview:
- Front end that produces the stopwatch command strobes consumed by the run/pause control FSM.
- Takes three raw, asynchronous, bouncy push-button levels (start, stop, reset).
- Synchronises and debounces each button, then emits at most one single-cycle command pulse per clock.
- Pulses fire on debounced press only. A held button produces exactly one pulse.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a level change. Legal range ≥2.
- CNT_W, 20: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- btn_start_raw  input  1  raw start button, active-high, asynchronous to clk
- btn_stop_raw  input  1  raw stop button, active-high, asynchronous
- btn_reset_raw  input  1  raw reset button, active-high, asynchronous
- start  output  1  one-cycle start command pulse
- stop  output  1  one-cycle stop command pulse
- reset  output  1  one-cycle reset command pulse
- btn_level  output  3  debounced levels {reset,stop,start}, for status/LEDs

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). On rst_n low, all flops clear immediately: synchronisers, counters, debounced levels, btn_level=3'b000, start/stop/reset=0.
- Per button, 2-flop synchroniser:
  - sync1 <= raw; sync2 <= sync1.
- Per button, debounce:
  - Registers: stable level (reset 0) and counter cnt (reset 0).
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0, and rise flag = sync2.
  - Else: cnt <= cnt+1.
  - A bounce back to the old level before the count completes clears cnt. No partial credit.
- Latency:
  - Raw first sampled high at edge E0 and held: debounced level rises at edge E0+DEBOUNCE_CYCLES+1.
  - The command pulse is registered on that same edge and is high for exactly that one following cycle.
- Release: debounced with the same rule. No pulse on release.
- Held button: one pulse only. A new pulse requires a debounced release, then a debounced press.
- Simultaneous rises in the same cycle:
  - Exactly one output pulses, with priority stop > start > reset.
  - Losing events are dropped, not queued.
  - The losers' btn_level bits still update.
- Outputs start/stop/reset are registered, never all zero-glitched, and mutually exclusive every cycle.
- Reset mid-debounce: the count is discarded. A button held across rst_n deassertion is treated as a fresh press and pulses DEBOUNCE_CYCLES+1 edges after the first post-reset sampling edge.
- Counter width: cnt never exceeds DEBOUNCE_CYCLES-1, so it never wraps.

Decomposition:
- Shared stopwatch constants include file holds:
  - default DEBOUNCE_CYCLES;
  - button index localparams BTN_START=0, BTN_STOP=1, BTN_RESET=2 (bit positions in btn_level);
  - status encodings IDLE=2'b00, RUNNING=2'b01, PAUSED=2'b10 shared with the control FSM.
- One natural sub-module: btn_debounce.
  - Contents: synchroniser plus counter plus stable level.
  - Outputs: level and rise strobe.
  - Parameterised by DEBOUNCE_CYCLES and CNT_W.
  - Instantiated three times.
- Top level performs priority arbitration and output registering.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
- Clean press: raw start high at edge 10, held. Response: start=1 only in the cycle after edge 15; btn_level[0]=1 from edge 15; stop=reset=0 throughout.
- Bounce: raw stop toggles high 2 cycles, low 1, high held from edge 20. Response: no pulse before edge 25; stop pulse after edge 25 only.
- Hold and release: start held 50 cycles then released, then pressed again. Response: exactly two start pulses; none on release; btn_level[0] falls 5 edges after the release sample.
- Simultaneous: start and stop raw rise on the same edge. Response: one stop pulse only; btn_level=3'b011.
- Reset mid-operation: rst_n low while cnt=2 on start. Response: all outputs 0 immediately. With raw held after rst_n rises, start pulses 5 edges after the first post-reset edge.
- Glitch rejection: 3-cycle-wide reset pulse on raw. Response: no reset output; btn_level stays 3'b000.
